// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC scan sequencer: RTC register map,
// interface port ids, function/ready codes and the scan FSM state encoding.
package rtc_pkg;

    localparam logic [7:0] RTC_CTRL = 8'h00;
    localparam logic [7:0] RTC_SEG  = 8'h21;
    localparam logic [7:0] RTC_MIN  = 8'h22;
    localparam logic [7:0] RTC_HORA = 8'h23;
    localparam logic [7:0] RTC_DIA  = 8'h24;
    localparam logic [7:0] RTC_MES  = 8'h25;
    localparam logic [7:0] RTC_ANIO = 8'h26;

    localparam logic [7:0] PORT_DIR  = 8'h00;
    localparam logic [7:0] PORT_FUN  = 8'h01;
    localparam logic [7:0] PORT_DWH  = 8'h02;
    localparam logic [7:0] PORT_DWL  = 8'h03;
    localparam logic [7:0] PORT_NONE = 8'hFF;

    localparam logic [7:0] FUN_RD = 8'h01;
    localparam logic [7:0] FUN_WR = 8'h02;

    localparam logic [7:0] RDY_BUSY = 8'h00;
    localparam logic [7:0] RDY_DONE = 8'hFF;

    localparam logic [2:0] IDX_LAST = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DIR   = 3'd1,
        ST_WR_FUN   = 3'd2,
        ST_WAIT_CLR = 3'd3,
        ST_WAIT_SET = 3'd4,
        ST_CAPTURE  = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } scan_state_t;

    // Scan order: seconds, minutes, hours, day, month, year.
    function automatic logic [7:0] rtc_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    rtc_addr = RTC_SEG;
            3'd1:    rtc_addr = RTC_MIN;
            3'd2:    rtc_addr = RTC_HORA;
            3'd3:    rtc_addr = RTC_DIA;
            3'd4:    rtc_addr = RTC_MES;
            3'd5:    rtc_addr = RTC_ANIO;
            default: rtc_addr = RTC_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/rtc_scan_ctrl_if.sv
// Port-write / result bus between the scan sequencer (master) and the
// RTC bus-interface block (slave).
interface rtc_scan_ctrl_if;
    logic [7:0] id_port;
    logic [7:0] dpico;
    logic       writef;
    logic [7:0] ready_in;
    logic [7:0] datoext_in;
    logic [7:0] ampm_in;

    modport master (
        output id_port, dpico, writef,
        input  ready_in, datoext_in, ampm_in
    );

    modport slave (
        input  id_port, dpico, writef,
        output ready_in, datoext_in, ampm_in
    );
endinterface

// File: rtl/rtc_scan_timer.sv
// Periodic scan tick: free-running counter gated by auto_en, tick on the
// last count of each SCAN_PERIOD window.
module rtc_scan_timer #(
    parameter int SCAN_PERIOD = 10_000_000,
    parameter int CNT_W       = 24
) (
    input  logic clock,
    input  logic reset,
    input  logic auto_en,
    output logic tick
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Period counter, parked at zero whenever periodic scanning is off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (!auto_en) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign tick = auto_en && (cnt_r == CNT_LAST);
endmodule

// File: rtl/rtc_scan_ctrl.sv
// RTC scan sequencer: issues address/function writes for the six time
// registers in order, waits on the ready byte and captures each result.
module rtc_scan_ctrl
    import rtc_pkg::*;
#(
    parameter int SCAN_PERIOD = 10_000_000,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               auto_en,
    rtc_scan_ctrl_if.master    bus,
    output logic [7:0]         seg,
    output logic [7:0]         min,
    output logic [7:0]         hora,
    output logic [7:0]         dia,
    output logic [7:0]         mes,
    output logic [7:0]         anio,
    output logic               pm,
    output logic               busy,
    output logic               scan_done,
    output logic               timeout_err
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    scan_state_t state_r, state_next_s;
    logic [2:0]  idx_r, idx_next_s;
    logic [7:0]  tmo_r, tmo_next_s;
    logic        err_r, err_next_s;
    logic        busy_r, scan_done_r, writef_r, wr_next_s, cap_en_s, tick_s;
    logic [7:0]  id_port_r, id_next_s, dpico_r, dpico_next_s;
    logic [7:0]  seg_r, min_r, hora_r, dia_r, mes_r, anio_r;
    logic        pm_r;

    rtc_scan_timer #(.SCAN_PERIOD(SCAN_PERIOD), .CNT_W(CNT_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .auto_en (auto_en),
        .tick    (tick_s)
    );

    // Next-state, index and wait-timeout logic.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        tmo_next_s   = tmo_r;
        err_next_s   = err_r;
        cap_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start || tick_s) begin
                    state_next_s = ST_WR_DIR;
                    idx_next_s   = 3'd0;
                    err_next_s   = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_DIR: state_next_s = ST_WR_FUN;
            ST_WR_FUN: begin
                state_next_s = ST_WAIT_CLR;
                tmo_next_s   = 8'd0;
            end
            // A stale RDY_DONE from the previous read must not be taken as completion.
            ST_WAIT_CLR: begin
                if (bus.ready_in == RDY_BUSY) begin
                    state_next_s = ST_WAIT_SET;
                    tmo_next_s   = 8'd0;
                end else if (tmo_r == TMO_LAST) begin
                    state_next_s = ST_ERR;
                end else begin
                    tmo_next_s = tmo_r + 8'd1;
                end
            end
            ST_WAIT_SET: begin
                if (bus.ready_in == RDY_DONE) begin
                    state_next_s = ST_CAPTURE;
                end else if (tmo_r == TMO_LAST) begin
                    state_next_s = ST_ERR;
                end else begin
                    tmo_next_s = tmo_r + 8'd1;
                end
            end
            ST_CAPTURE: begin
                cap_en_s = 1'b1;
                if (idx_r == IDX_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    idx_next_s   = idx_r + 3'd1;
                    state_next_s = ST_WR_DIR;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            ST_ERR: begin
                err_next_s   = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        wr_next_s    = 1'b0;
        id_next_s    = PORT_NONE;
        dpico_next_s = dpico_r;
        case (state_next_s)
            ST_WR_DIR: begin
                wr_next_s    = 1'b1;
                id_next_s    = PORT_DIR;
                dpico_next_s = rtc_addr(idx_next_s);
            end
            ST_WR_FUN: begin
                wr_next_s    = 1'b1;
                id_next_s    = PORT_FUN;
                dpico_next_s = FUN_RD;
            end
            default: begin
                wr_next_s = 1'b0;
                id_next_s = PORT_NONE;
            end
        endcase
    end

    // Control state, status flags and bus output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 3'd0;
            tmo_r       <= 8'd0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            scan_done_r <= 1'b0;
            writef_r    <= 1'b0;
            id_port_r   <= PORT_NONE;
            dpico_r     <= 8'h00;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            tmo_r       <= tmo_next_s;
            err_r       <= err_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            scan_done_r <= (state_next_s == ST_DONE);
            writef_r    <= wr_next_s;
            id_port_r   <= id_next_s;
            dpico_r     <= dpico_next_s;
        end
    end

    // Time register bank; an aborted scan leaves unread registers untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_r  <= 8'h00;
            min_r  <= 8'h00;
            hora_r <= 8'h00;
            dia_r  <= 8'h00;
            mes_r  <= 8'h00;
            anio_r <= 8'h00;
            pm_r   <= 1'b0;
        end else if (cap_en_s) begin
            case (idx_r)
                3'd0: seg_r <= bus.datoext_in;
                3'd1: min_r <= bus.datoext_in;
                3'd2: begin
                    hora_r <= bus.datoext_in;
                    pm_r   <= bus.ampm_in[4];
                end
                3'd3: dia_r  <= bus.datoext_in;
                3'd4: mes_r  <= bus.datoext_in;
                3'd5: anio_r <= bus.datoext_in;
                default: seg_r <= seg_r;
            endcase
        end
    end

    assign bus.writef  = writef_r;
    assign bus.id_port = id_port_r;
    assign bus.dpico   = dpico_r;
    assign seg         = seg_r;
    assign min         = min_r;
    assign hora        = hora_r;
    assign dia         = dia_r;
    assign mes         = mes_r;
    assign anio        = anio_r;
    assign pm          = pm_r;
    assign busy        = busy_r;
    assign scan_done   = scan_done_r;
    assign timeout_err = err_r;
endmodule

// File: tb/tb_rtc_scan_ctrl.sv
// Bench for rtc_scan_ctrl: behavioural RTC interface responder, a table of
// scan vectors, and hand-written sequences for auto, merge and reset cases.
module tb_rtc_scan_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic       pm, busy, scan_done, timeout_err;

    rtc_scan_ctrl_if bus ();

    rtc_scan_ctrl #(.SCAN_PERIOD(100), .TIMEOUT(255), .CNT_W(24)) dut (
        .clock(clock), .reset(reset), .start(start), .auto_en(auto_en), .bus(bus),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .pm(pm), .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural RTC interface ----------------
    logic [47:0] cur_dat = 48'h0;
    int          stuck_idx = -1;
    int          mdl_lat = 41;
    int          mdl_cnt = 0;
    int          m_idx = 0;
    bit          mdl_act = 1'b0;
    logic [7:0]  last_addr = 8'h00;

    always @(negedge clock) begin
        if (!reset) begin
            mdl_act = 1'b0;
            mdl_cnt = 0;
            bus.ready_in = 8'hFF;
            bus.datoext_in = 8'h00;
        end else begin
            if (bus.writef && bus.id_port == 8'h00) last_addr = bus.dpico;
            if (bus.writef && bus.id_port == 8'h01 && bus.dpico == 8'h01) begin
                m_idx = int'(last_addr) - 33;
                if (m_idx != stuck_idx) begin
                    mdl_act = 1'b1;
                    mdl_cnt = 0;
                end
            end
            if (mdl_act) begin
                mdl_cnt++;
                if (mdl_cnt == 2) bus.ready_in = 8'h00;
                if (mdl_cnt >= mdl_lat) begin
                    bus.datoext_in = cur_dat[8*(5-m_idx) +: 8];
                    bus.ready_in = 8'hFF;
                    mdl_act = 1'b0;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [15:0] wr_log[$];
    int          scan_starts[$];
    int          done_cnt = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.writef) begin
            wr_log.push_back({bus.id_port, bus.dpico});
            if (bus.id_port == 8'h00 && bus.dpico == 8'h21) scan_starts.push_back(cyc);
        end
        if (scan_done) done_cnt++;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [47:0] dat;
        logic [7:0]  ampm;
        int          stuck;
        logic [47:0] exp_regs;
        logic        exp_pm;
        logic        exp_err;
        int          exp_wr;
        int          exp_done;
        int          exp_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic run_scan(input string tag, input vec_t v);
        int  busy_cyc;
        bit  ok;
        logic [15:0] exp_w;
        cur_dat = v.dat;
        bus.ampm_in = v.ampm;
        stuck_idx = v.stuck;
        mdl_lat = 41;
        wr_log.delete();
        done_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1'b1);
        busy_cyc = 1;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            busy_cyc++;
        end
        check({tag, "_idle_reached"}, ok, 1'b1);
        check({tag, "_regs"}, {seg, min, hora, dia, mes, anio}, v.exp_regs);
        check({tag, "_pm"}, pm, v.exp_pm);
        check({tag, "_timeout_err"}, timeout_err, v.exp_err);
        check({tag, "_scan_done_cnt"}, done_cnt, v.exp_done);
        check({tag, "_write_cnt"}, wr_log.size(), v.exp_wr);
        if (v.exp_busy > 0) check({tag, "_busy_cycles"}, busy_cyc, v.exp_busy);
        for (int k = 0; k < wr_log.size(); k++) begin
            exp_w = (k % 2 == 0) ? {8'h00, 8'(33 + k / 2)} : 16'h0101;
            check($sformatf("%s_write%0d", tag, k), wr_log[k], exp_w);
        end
    endtask

    vec_t hv;
    bit   ok2;

    initial begin
        vecs[0] = '{48'h453011230616, 8'h10, -1, 48'h453011230616, 1'b1, 1'b0, 12, 1, 0};
        // ready never drops after the first function write: abort, regs unchanged
        vecs[1] = '{48'h998877665544, 8'h00,  0, 48'h453011230616, 1'b1, 1'b1,  2, 0, 258};
        vecs[2] = '{48'h595923311299, 8'h00, -1, 48'h595923311299, 1'b0, 1'b0, 12, 1, 0};
        // hour read times out: seg/min updated, hora and pm keep old values
        vecs[3] = '{48'h123456780910, 8'h10,  2, 48'h123423311299, 1'b0, 1'b1,  6, 0, 0};
        vecs[4] = '{48'h010203040506, 8'hEF, -1, 48'h010203040506, 1'b0, 1'b0, 12, 1, 0};

        bus.ampm_in = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_id_port", bus.id_port, 8'hFF);
        check("rst_dpico", bus.dpico, 8'h00);
        check("rst_writef", bus.writef, 1'b0);
        check("rst_regs", {seg, min, hora, dia, mes, anio, pm}, 49'h0);
        check("rst_flags", {busy, scan_done, timeout_err}, 3'b000);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 5; i++) run_scan($sformatf("vec%0d", i), vecs[i]);

        // periodic scans every 100 cycles; start during a scan is ignored
        mdl_lat = 5;
        stuck_idx = -1;
        scan_starts.delete();
        done_cnt = 0;
        auto_en = 1'b1;
        for (int n = 0; n < 350; n++) begin
            @(negedge clock);
            start = (n == 110);
        end
        start = 1'b0;
        auto_en = 1'b0;
        repeat (60) @(negedge clock);
        check("auto_scan_cnt", scan_starts.size(), 3);
        check("auto_done_cnt", done_cnt, 3);
        if (scan_starts.size() == 3) begin
            check("auto_interval1", scan_starts[1] - scan_starts[0], 100);
            check("auto_interval2", scan_starts[2] - scan_starts[1], 100);
        end

        // start coinciding with the auto tick yields a single scan
        wr_log.delete();
        done_cnt = 0;
        @(negedge clock);
        auto_en = 1'b1;
        repeat (99) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        auto_en = 1'b0;
        check("merge_busy_rise", busy, 1'b1);
        repeat (120) @(negedge clock);
        check("merge_write_cnt", wr_log.size(), 12);
        check("merge_done_cnt", done_cnt, 1);
        check("merge_idle", busy, 1'b0);

        // reset asserted during WAIT_SET of the day read
        cur_dat = 48'h776655443322;
        bus.ampm_in = 8'h10;
        mdl_lat = 41;
        wr_log.delete();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ok2 = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            if (wr_log.size() >= 8 && bus.ready_in == 8'h00) begin
                ok2 = 1'b1;
                break;
            end
        end
        check("rstmid_reached_wait", ok2, 1'b1);
        repeat (3) @(negedge clock);
        check("rstmid_pre_regs", {seg, min, hora}, 24'h776655);
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_writef", bus.writef, 1'b0);
        check("rstmid_id_port", bus.id_port, 8'hFF);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_regs", {seg, min, hora, dia, mes, anio, pm}, 49'h0);
        reset = 1'b1;
        @(negedge clock);
        hv = '{48'h102008150924, 8'h10, -1, 48'h102008150924, 1'b1, 1'b0, 12, 1, 0};
        run_scan("post_rst", hv);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rtc_scan_ctrl.md
Name: rtc_scan_ctrl

Overview:
- Upstream sequencer for the RTC bus-interface block.
- Drives that block's port-write interface (id_port/dpico/writef) to read six RTC time registers in a fixed order: seconds, minutes, hours, day, month, year.
- Handshakes on its ready byte and captures each datoext result into a register bank.
- Lets display/UI logic get a time snapshot without PicoBlaze involvement; scans start on request or periodically.

Parameters:
SCAN_PERIOD, 10_000_000, clock cycles between automatic scans when auto_en=1 (min 64)
TIMEOUT, 255, max cycles spent in any ready-wait state before abort
CNT_W, 24, width of period counter; must hold SCAN_PERIOD-1

Ports:
clock  in  1  system clock
reset  in  1  active-low asynchronous reset
start  in  1  one-cycle scan request
auto_en  in  1  enables periodic scans
ready_in  in  8  ready byte from RTC interface (8'h00 busy, 8'hFF done)
datoext_in  in  8  read data from RTC interface
ampm_in  in  8  AM/PM/format byte from RTC interface; bit4 = PM
id_port  out  8  port id to RTC interface
dpico  out  8  port data to RTC interface
writef  out  1  port write strobe, one cycle per write
seg, min, hora, dia, mes, anio  out  8 each  captured BCD time registers
pm  out  1  ampm_in[4] sampled with hora
busy  out  1  high from scan start until return to IDLE
scan_done  out  1  one-cycle pulse after all six captures succeed
timeout_err  out  1  sticky; set on abort, cleared at next scan start

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: id_port=8'hFF, dpico=8'h00, writef=0, all time regs=8'h00, pm=0, busy=0, scan_done=0, timeout_err=0, idx=0, period counter=0, state=IDLE.
- RTC address table, indexed by idx 0..5: 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26.
- Read function code is 8'h01.
- Scan trigger in IDLE: start=1, or auto_en=1 and period counter == SCAN_PERIOD-1.
  - Simultaneous start and auto tick produce one scan.
  - start while busy=1 is ignored (no queueing).
- Period counter:
  - Counts while auto_en=1.
  - Wraps to 0 at SCAN_PERIOD-1.
  - Held at 0 when auto_en=0.
  - A tick arriving while busy is dropped.
- FSM states and transitions:
  - IDLE: on trigger -> WR_DIR, with idx=0, busy=1, timeout_err=0.
  - WR_DIR: writef=1, id_port=8'h00, dpico=addr[idx] for exactly one cycle -> WR_FUN.
  - WR_FUN: writef=1, id_port=8'h01, dpico=8'h01 for one cycle -> WAIT_CLR.
  - WAIT_CLR: wait until ready_in==8'h00 (interface has started; stale 8'hFF from the previous transaction is ignored) -> WAIT_SET.
  - WAIT_SET: wait until ready_in==8'hFF -> CAPTURE.
  - CAPTURE: load datoext_in into register[idx]; when idx==2 also load pm<=ampm_in[4].
    - If idx==5 -> DONE.
    - Else idx<=idx+1 -> WR_DIR.
  - DONE: scan_done=1 for one cycle, busy<=0 -> IDLE.
  - ERR: timeout_err<=1, busy<=0 -> IDLE. Registers captured before the abort keep their new values; the rest keep their old values. scan_done is not pulsed.
- Timeout counter:
  - 8-bit, cleared on entry to WAIT_CLR and to WAIT_SET.
  - Increments each wait cycle.
  - Reaching TIMEOUT -> ERR.
- Outside WR_DIR/WR_FUN: writef=0, id_port=8'hFF (matches no interface port), dpico holds its last value.
- Latency: with a 41-cycle interface transaction, one full scan takes about 6 × 45 cycles.
- Reset asserted mid-scan: everything returns to reset values immediately. The RTC interface has its own reset and is not restarted by this block.

Decomposition:
- Shared package rtc_pkg holds:
  - RTC address constants: RTC_SEG=8'h21 … RTC_ANIO=8'h26, RTC_CTRL=8'h00.
  - Port-id constants: PORT_DIR=8'h00, PORT_FUN=8'h01, PORT_DWH=8'h02, PORT_DWL=8'h03.
  - Function codes: FUN_RD=8'h01, FUN_WR=8'h02.
  - Ready codes: RDY_BUSY=8'h00, RDY_DONE=8'hFF.
  - FSM state enum.
- One natural sub-module: rtc_scan_timer, the periodic tick generator (counter + auto_en gating).
- The FSM and register bank stay in the top module.

Test Plan:
- Reset then pulse start; behavioural interface model returns datoext 8'h45, 8'h30, 8'h11, 8'h23, 8'h06, 8'h16 with ampm_in=8'h10 -> exactly 12 writef pulses, id/data pairs (00,21)(01,01)…(00,26)(01,01); seg=45, min=30, hora=11, dia=23, mes=06, anio=16, pm=1; one scan_done pulse; busy low afterwards.
- Model never drops ready_in from 8'hFF after the first function write -> ERR after TIMEOUT=255 wait cycles; timeout_err=1, no scan_done, all regs unchanged. Next start clears timeout_err.
- auto_en=1, SCAN_PERIOD=100, fast model -> scans begin every 100 cycles. A start pulse asserted during a scan does not cause an extra scan.
- start and auto tick in the same cycle -> exactly 6 address writes, one scan_done.
- reset asserted during WAIT_SET of idx=3 -> next cycle: writef=0, id_port=8'hFF, busy=0, regs=00. A following start scans from idx=0 (8'h21).
- Timeout in the hour read (idx=2) with seg/min already captured -> seg, min updated; hora and pm unchanged; timeout_err=1.
